// File: rtl/dcm_pkg.sv
// Shared types and default widths for the dcmctrl encoder path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package dcm_pkg;

    // Drive direction remembered between ticks so brake/coast keep stepping the same way.
    typedef enum logic {
        DIR_FWD = 1'b0,
        DIR_REV = 1'b1
    } dcm_dir_t;

    // Default counter widths; the SPI register map sizes its fields from these.
    localparam int DCM_POS_W = 24;
    localparam int DCM_PER_W = 16;

endpackage

// File: rtl/dcm_glitch_filter.sv
// Two-flop synchronizer, level de-glitch filter and registered edge strobes.
// Latency: rise/fall strobe one cycle after the (FILTER_LEN+2)th edge that samples the new level.
// Backpressure: none; strobes are fire-and-forget.
//
// Ports: clk, reset (async, active-high), pulse_in (raw async input),
//        filt (accepted level), rise/fall (one-cycle strobes, fall only when BOTH_EDGES).
module dcm_glitch_filter #(
    parameter int FILTER_LEN = 4,
    parameter bit BOTH_EDGES = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic pulse_in,
    output logic filt,
    output logic rise,
    output logic fall
);

    localparam logic [7:0] LAST = 8'(FILTER_LEN - 1);

    logic       sync1;
    logic       sync2;
    logic [7:0] cnt;
    logic       accept;

    // sync2 has disagreed with filt for FILTER_LEN consecutive cycles including this one.
    assign accept = (sync2 != filt) && (cnt == LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            filt  <= 1'b0;
            cnt   <= '0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            sync1 <= pulse_in;
            sync2 <= sync1;
            // Strobes launch on the same edge that updates filt.
            rise  <= accept && sync2;
            fall  <= accept && !sync2 && BOTH_EDGES;
            if (sync2 == filt) begin
                cnt <= '0;
            end else if (cnt == LAST) begin
                filt <= sync2;
                cnt  <= '0;
            end else begin
                cnt <= cnt + 8'd1;
            end
        end
    end

endmodule

// File: rtl/dcm_pulse_cond.sv
// Encoder pulse conditioner: filtered count ticks, signed position and pulse-period measurement.
// Latency: pulse_tick one cycle after the (FILTER_LEN+2)th edge sampling pulse_in high; position/period one cycle after tick.
// Backpressure: none; every accepted pulse is counted immediately.
//
// Ports: clk, reset (async, active-high), pulse_in, dir_fwd/dir_rev (drive direction),
//        pos_load/pos_load_val (position preset), pulse_tick, position, period,
//        period_valid, stalled.
// Build option: define DCM_PULSE_BOTH_EDGES_EN to tick on both filtered edges.
module dcm_pulse_cond
    import dcm_pkg::*;
#(
    parameter int FILTER_LEN = 4,
    parameter int POS_W      = DCM_POS_W,
    parameter int PER_W      = DCM_PER_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pulse_in,
    input  logic             dir_fwd,
    input  logic             dir_rev,
    input  logic             pos_load,
    input  logic [POS_W-1:0] pos_load_val,
    output logic             pulse_tick,
    output logic [POS_W-1:0] position,
    output logic [PER_W-1:0] period,
    output logic             period_valid,
    output logic             stalled
);

`ifdef DCM_PULSE_BOTH_EDGES_EN
    localparam bit BOTH_EDGES = 1'b1;
`else
    localparam bit BOTH_EDGES = 1'b0;
`endif

    localparam logic [PER_W-1:0] PER_MAX = '1;

    logic             filt;
    logic             rise;
    logic             fall;
    logic             step_rev;
    logic             seen;
    logic [PER_W-1:0] per_cnt;
    dcm_dir_t         last_dir;

    dcm_glitch_filter #(
        .FILTER_LEN(FILTER_LEN),
        .BOTH_EDGES(BOTH_EDGES)
    ) u_filter (
        .clk     (clk),
        .reset   (reset),
        .pulse_in(pulse_in),
        .filt    (filt),
        .rise    (rise),
        .fall    (fall)
    );

    // Edge strobes are coincident with the new filtered level, so qualifying
    // them with it keeps a stray strobe from ever counting the wrong polarity.
    assign pulse_tick = (rise && filt) || (fall && !filt);

    // Exactly one drive active decides the step; brake/coast reuse the last one.
    assign step_rev = (dir_fwd ^ dir_rev) ? dir_rev : (last_dir == DIR_REV);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_dir     <= DIR_FWD;
            position     <= '0;
            per_cnt      <= '0;
            period       <= PER_MAX;
            period_valid <= 1'b0;
            stalled      <= 1'b0;
            seen         <= 1'b0;
        end else begin
            if (dir_fwd ^ dir_rev) begin
                last_dir <= dir_rev ? DIR_REV : DIR_FWD;
            end

            // A load in the same cycle as a tick wins; that tick's step is dropped.
            if (pos_load) begin
                position <= pos_load_val;
            end else if (pulse_tick) begin
                position <= step_rev ? position - POS_W'(1) : position + POS_W'(1);
            end

            if (pulse_tick) begin
                per_cnt <= '0;
                seen    <= 1'b1;
                if (stalled) begin
                    // First tick after a stall only re-arms; its interval is meaningless.
                    stalled <= 1'b0;
                end else if (per_cnt == PER_MAX) begin
                    // Interval overflowed on this very cycle: report it as unmeasurable.
                    period       <= PER_MAX;
                    period_valid <= 1'b0;
                end else if (seen) begin
                    period       <= per_cnt + PER_W'(1);
                    period_valid <= 1'b1;
                end
            end else if (per_cnt == PER_MAX) begin
                stalled      <= 1'b1;
                period       <= PER_MAX;
                period_valid <= 1'b0;
            end else begin
                per_cnt <= per_cnt + PER_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_dcm_pulse_cond.sv
module tb_dcm_pulse_cond;

    localparam int FL = 4;
    localparam int PW = 24;
    localparam int QW = 16;
    localparam int PMAX = (1 << QW) - 1;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          pulse_in = 1'b0;
    logic          dir_fwd = 1'b0;
    logic          dir_rev = 1'b0;
    logic          pos_load = 1'b0;
    logic [PW-1:0] pos_load_val = '0;
    logic          pulse_tick;
    logic [PW-1:0] position;
    logic [QW-1:0] period;
    logic          period_valid;
    logic          stalled;

    int n_cmp = 0;
    int n_bad = 0;
    int n_ticks = 0;

    always #5 clk = ~clk;

    dcm_pulse_cond #(.FILTER_LEN(FL), .POS_W(PW), .PER_W(QW)) dut (
        .clk         (clk),
        .reset       (reset),
        .pulse_in    (pulse_in),
        .dir_fwd     (dir_fwd),
        .dir_rev     (dir_rev),
        .pos_load    (pos_load),
        .pos_load_val(pos_load_val),
        .pulse_tick  (pulse_tick),
        .position    (position),
        .period      (period),
        .period_valid(period_valid),
        .stalled     (stalled)
    );

    // ---------------- reference model ----------------
    // The filter is modelled as a sliding window: the level flips once the last
    // FL samples that have crossed the two-flop synchronizer all agree on a new value.
    bit            hist[$];
    bit            m_filt, m_tick, m_last_rev, m_seen, m_valid, m_stalled;
    logic [PW-1:0] m_pos;
    int            m_period;
    int            e_now, e_last_tick;

    task automatic model_reset();
        hist.delete();
        repeat (FL + 2) hist.push_back(1'b0);
        m_filt = 0; m_tick = 0; m_last_rev = 0; m_seen = 0; m_valid = 0; m_stalled = 0;
        m_pos = '0; m_period = PMAX; e_now = 0; e_last_tick = 0;
    endtask

    task automatic model_step();
        bit rev_step;
        bit v;
        bit same;
        int gap;
        e_now++;
        rev_step = (dir_fwd ^ dir_rev) ? dir_rev : m_last_rev;
        if (dir_fwd ^ dir_rev) m_last_rev = dir_rev;
        if (pos_load) m_pos = pos_load_val;
        else if (m_tick) m_pos = rev_step ? m_pos - 1 : m_pos + 1;
        // cycles elapsed since the last tick edge, saturating at the counter limit
        gap = e_now - e_last_tick - 1;
        if (gap > PMAX) gap = PMAX;
        if (m_tick) begin
            if (m_stalled) m_stalled = 0;
            else if (gap == PMAX) begin m_period = PMAX; m_valid = 0; end
            else if (m_seen) begin m_period = e_now - e_last_tick; m_valid = 1; end
            m_seen = 1;
            e_last_tick = e_now;
        end else if (gap == PMAX) begin
            m_stalled = 1; m_period = PMAX; m_valid = 0;
        end
        hist.push_back(pulse_in);
        v = hist[hist.size() - 3];
        same = 1;
        for (int i = 0; i < FL; i++) if (hist[hist.size() - 3 - i] != v) same = 0;
        m_tick = 0;
        if (same && v != m_filt) begin
            m_filt = v;
`ifdef DCM_PULSE_BOTH_EDGES_EN
            m_tick = 1;
`else
            m_tick = v;
`endif
        end
        while (hist.size() > FL + 4) void'(hist.pop_front());
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // One clock: DUT and model both consume the inputs held across the edge.
    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        chk("m_tick", pulse_tick, m_tick);
        chk("m_position", position, m_pos);
        chk("m_period", period, m_period);
        chk("m_period_valid", period_valid, m_valid);
        chk("m_stalled", stalled, m_stalled);
        if (pulse_tick) n_ticks++;
    endtask

    task automatic do_reset();
        reset = 1'b1; pulse_in = 0; dir_fwd = 0; dir_rev = 0; pos_load = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_tick", pulse_tick, 0);
        chk("rst_position", position, 0);
        chk("rst_period", period, 32'hFFFF);
        chk("rst_valid", period_valid, 0);
        chk("rst_stalled", stalled, 0);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic pulse(input int hi, input int total);
        pulse_in = 1'b1;
        repeat (hi) step();
        pulse_in = 1'b0;
        repeat (total - hi) step();
    endtask

    typedef struct {
        int width;
        bit fwd;
        bit rev;
        int exp_ticks;
        int exp_delta;
    } vec_t;

    vec_t vecs[10];

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int first_at;
        logic [PW-1:0] exp_pos;

        vecs[0] = '{20, 1, 0, 1,  1};  // clean forward pulse
        vecs[1] = '{ 3, 1, 0, 0,  0};  // glitch shorter than filter
        vecs[2] = '{ 4, 1, 0, 1,  1};  // exactly FILTER_LEN cycles: accepted
        vecs[3] = '{ 1, 1, 0, 0,  0};
        vecs[4] = '{10, 0, 1, 1, -1};  // reverse
        vecs[5] = '{10, 0, 0, 1, -1};  // coast keeps reverse
        vecs[6] = '{10, 1, 0, 1,  1};
        vecs[7] = '{10, 1, 1, 1,  1};  // brake keeps forward
        vecs[8] = '{ 5, 0, 0, 1,  1};
        vecs[9] = '{ 2, 0, 1, 0,  0};

        // A: reset values, first-tick latency, forward step
        do_reset();
        dir_fwd = 1; pulse_in = 1; first_at = 0;
        for (int k = 1; k <= 12; k++) begin
            step();
            if (pulse_tick && first_at == 0) first_at = k;
        end
        chk("latency_edges", first_at, FL + 2);
        chk("first_pos", position, 1);
        pulse_in = 0;
        repeat (10) step();

        // B: reverse pulses every 400 cycles
        do_reset();
        dir_rev = 1;
        pulse(20, 400);
        chk("p1_valid", period_valid, 0);
        pulse(20, 400);
        chk("p2_valid", period_valid, 1);
        chk("p2_period", period, 400);
        repeat (3) pulse(20, 400);
        chk("rev5_pos", position, 24'hFFFFFB);
        chk("rev5_period", period, 400);

        // C: table of pulse widths and drive states
        dir_rev = 0;
        pos_load = 1; pos_load_val = 24'h10;
        step();
        pos_load = 0;
        exp_pos = 24'h10;
        foreach (vecs[i]) begin
            dir_fwd = vecs[i].fwd; dir_rev = vecs[i].rev;
            n_ticks = 0;
            pulse(vecs[i].width, vecs[i].width + 30);
            exp_pos = exp_pos + PW'(vecs[i].exp_delta);
            chk($sformatf("vec%0d_ticks", i), n_ticks, vecs[i].exp_ticks);
            chk($sformatf("vec%0d_pos", i), position, exp_pos);
        end

        // D: wrap, then load coincident with a tick
        dir_fwd = 1; dir_rev = 0;
        pos_load = 1; pos_load_val = 24'hFFFFFF;
        step();
        pos_load = 0;
        pulse(20, 30);
        chk("wrap_pos", position, 0);
        pulse_in = 1;
        for (int k = 0; k < 20 && !pulse_tick; k++) step();
        chk("load_tick_seen", pulse_tick, 1);
        pos_load = 1; pos_load_val = 24'h000100;
        step();
        pos_load = 0;
        chk("load_pos", position, 24'h000100);
        pulse_in = 0;
        repeat (20) step();
        chk("load_pos_hold", position, 24'h000100);

        // E: reset while the pulse is still high
        pulse_in = 1;
        repeat (8) step();
        #2 reset = 1'b1;
        #1;
        chk("arst_pos", position, 0);
        chk("arst_tick", pulse_tick, 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        model_reset();
        n_ticks = 0;
        repeat (12) step();
        chk("arst_refilter_ticks", n_ticks, 1);
        chk("arst_refilter_pos", position, 1);
        pulse_in = 0;
        repeat (10) step();

        // F: randomized runs against the model
        for (int r = 0; r < 300; r++) begin
            int len;
            len = $urandom_range(1, 12);
            pulse_in = $urandom_range(0, 1);
            dir_fwd = $urandom_range(0, 1);
            dir_rev = $urandom_range(0, 1);
            pos_load = ($urandom_range(0, 19) == 0);
            pos_load_val = PW'($urandom);
            step();
            pos_load = 0;
            repeat (len - 1) step();
        end
        pulse_in = 0;

        // G: stall, re-arm, then a valid period
        pulse(20, 30);
        repeat (65540) step();
        chk("stall_flag", stalled, 1);
        chk("stall_period", period, 32'hFFFF);
        chk("stall_valid", period_valid, 0);
        pulse(20, 500);
        chk("rearm_stalled", stalled, 0);
        chk("rearm_period", period, 32'hFFFF);
        chk("rearm_valid", period_valid, 0);
        pulse(20, 500);
        chk("post_stall_period", period, 500);
        chk("post_stall_valid", period_valid, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dcm_pulse_cond.md
Name: dcm_pulse_cond

Overview:
Per-channel encoder-pulse conditioner that feeds the dcmctrl control core. It synchronizes and de-glitches a raw motor_pulse line and emits one-cycle count ticks. It also keeps a signed-direction position count and measures the pulse period used for speed regulation. dcmctrl instantiates one per motor channel; position and period are read back over SPI.

Parameters:
FILTER_LEN, 4, consecutive synced cycles an input level must hold before it is accepted (1..255; 1 = no filtering)
POS_W, 24, position counter width
PER_W, 16, period counter width

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
pulse_in  in  1  raw encoder pulse, asynchronous to clk
dir_fwd  in  1  motor_left drive of this channel
dir_rev  in  1  motor_right drive of this channel
pos_load  in  1  load position from pos_load_val (one-cycle strobe)
pos_load_val  in  POS_W  value for pos_load
pulse_tick  out  1  one-cycle strobe per accepted pulse
position  out  POS_W  current position, two's complement
period  out  PER_W  clk cycles between the last two ticks
period_valid  out  1  period holds a real measurement
stalled  out  1  no tick for 2^PER_W-1 cycles

Behaviour:
- Reset (async): sync FFs, filtered level, filter count = 0; position = 0; period = all-ones; period_valid = 0; stalled = 0; pulse_tick = 0; last_dir = forward; seen = 0.
- Sync: two flops, sync1 <= pulse_in, sync2 <= sync1.
- Filter, evaluated each edge:
  - if sync2 == filt: cnt <= 0.
  - else if cnt == FILTER_LEN-1: filt <= sync2, cnt <= 0.
  - else: cnt <= cnt+1.
- Pulses on sync2 shorter than FILTER_LEN cycles are rejected.
- Tick: pulse_tick is registered, high for exactly one cycle when filt goes 0->1.
- Latency: pulse_tick is high in the cycle after the (FILTER_LEN+2)th rising edge, counting the first edge that samples pulse_in high.
- Direction on a tick:
  - dir_fwd & !dir_rev: +1, last_dir <= forward.
  - dir_rev & !dir_fwd: -1, last_dir <= reverse.
  - both or neither (brake or coast): step by last_dir.
- last_dir also updates on any cycle with exactly one of dir_fwd/dir_rev high, tick or not.
- Position wraps modulo 2^POS_W; no saturation.
- pos_load: position <= pos_load_val on the next edge. If a tick occurs in the same cycle, the load wins and that tick's step is discarded; the pulse_tick strobe and the period update still occur.
- Period: per_cnt increments every cycle and saturates at 2^PER_W-1.
  - On tick with seen=1 and stalled=0: period <= per_cnt+1, period_valid <= 1.
  - On every tick: per_cnt <= 0, seen <= 1.
- Stall:
  - When per_cnt reaches all-ones: stalled <= 1, period <= all-ones, period_valid <= 0.
  - The next tick clears stalled and does not update period; the tick after that produces a valid period.
- Reset mid-pulse: all state cleared immediately. A still-high pulse_in is re-filtered from zero and produces a tick once it is accepted.

Optional Feature:
DCM_PULSE_BOTH_EDGES_EN
- Defined: both filt edges (0->1 and 1->0) generate pulse_tick, giving 2x position resolution. Period is measured between consecutive edges of either polarity.
- Undefined: rising edges only, as above.

Decomposition:
- Shared package dcm_pkg holds:
  - the direction type (forward/reverse);
  - default widths DCM_POS_W=24 and DCM_PER_W=16, also used by dcmctrl's SPI register map.
- Sub-module dcm_glitch_filter holds the sync flops, filter counter and edge strobe.
  - Parameters: FILTER_LEN, BOTH_EDGES.
  - Outputs: filt, rise, fall.
- Top level holds direction, position and period logic.

Test Plan:
- Single clean pulse, FILTER_LEN=4, pulse_in high 20 cycles -> exactly one pulse_tick, 6 edges after the first high sample; position 0->1 with dir_fwd=1.
- 3-cycle glitch on pulse_in, FILTER_LEN=4 -> no pulse_tick, position unchanged.
- Pulses every 400 cycles, dir_rev=1, five pulses -> position 0 -> -5 (0xFFFFFB); period_valid rises at the second tick; period=400.
- Forward drive then dir_fwd=dir_rev=0, 3 pulses -> position keeps incrementing. Position 0xFFFFFF plus one fwd tick -> wraps to 0x000000.
- pos_load with value 0x000100 coincident with a tick -> position=0x000100 next cycle, pulse_tick still strobes, no step applied.
- No pulse for 65535 cycles -> stalled=1, period=0xFFFF, period_valid=0. Next pulse -> stalled=0 with period unchanged; pulse 500 cycles later -> period=500, period_valid=1.
